// File: rtl/qspi_shift_engine_pkg.sv
// Shared constants for the QSPI shift engine: FSM encodings, pad output-enable
// patterns and beat widths.
package qspi_shift_engine_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_TAIL  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [3:0] OE_SINGLE  = 4'b0001;
  localparam logic [3:0] OE_QUAD_TX = 4'b1111;
  localparam logic [3:0] OE_QUAD_RX = 4'b0000;

  localparam int BITS_PER_BEAT_SINGLE = 1;
  localparam int BITS_PER_BEAT_QUAD   = 4;

  // Single mode always drives MOSI on IO0; the direction bit only matters in quad mode.
  function automatic logic [3:0] oe_for_mode(input logic quad, input logic dir_rx);
    logic [3:0] oe;
    if (quad) begin
      oe = dir_rx ? OE_QUAD_RX : OE_QUAD_TX;
    end else begin
      oe = OE_SINGLE;
    end
    return oe;
  endfunction

endpackage

// File: rtl/qspi_shift_engine_if.sv
// Command-sequencer side of the QSPI shift engine: start/ready handshake,
// transmit word in, received word out.
interface qspi_shift_engine_if #(
  parameter int DATA_W = 8
);

  logic              start;
  logic              quad;
  logic              dir_rx;
  logic [DATA_W-1:0] tx_data;
  logic              ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (
    output start,
    output quad,
    output dir_rx,
    output tx_data,
    input  ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  start,
    input  quad,
    input  dir_rx,
    input  tx_data,
    output ready,
    output rx_data,
    output rx_valid
  );

endinterface

// File: rtl/qspi_shift_engine.sv
// SPI mode-0 word serializer/deserializer driven by the clock divider's
// sclk_rise/sclk_fall ticks, in single-bit or quad mode.
module qspi_shift_engine
  import qspi_shift_engine_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  qspi_shift_engine_if.slave  cmd,
  input  logic                sclk_rise,
  input  logic                sclk_fall,
  output logic                sclk_ena,
  output logic                sclk,
  output logic [3:0]          io_out,
  output logic [3:0]          io_oe,
  input  logic [3:0]          io_in
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BEATS_SINGLE = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] BEATS_QUAD   = CNT_W'(DATA_W / 4);

  state_t            state_r;
  logic [DATA_W-1:0] tx_sh_r;
  logic [DATA_W-1:0] rx_sh_r;
  logic              quad_r;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic              sclk_r;
  logic              sclk_ena_r;
  logic [3:0]        io_oe_r;
  logic              ready_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;

  logic [CNT_W-1:0]  beats_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [DATA_W-1:0] rx_next_s;
  logic [DATA_W-1:0] tx_next_s;
  logic [3:0]        io_out_s;

  // Beat bookkeeping and next shift-register values for the current mode.
  always_comb begin
    beats_s   = BEATS_SINGLE;
    cnt_inc_s = beat_cnt_r + CNT_W'(1);
    rx_next_s = rx_sh_r;
    tx_next_s = tx_sh_r;
    if (quad_r) begin
      beats_s   = BEATS_QUAD;
      rx_next_s = (rx_sh_r << BITS_PER_BEAT_QUAD) | DATA_W'(io_in);
      tx_next_s = tx_sh_r << BITS_PER_BEAT_QUAD;
    end else begin
      beats_s   = BEATS_SINGLE;
      rx_next_s = (rx_sh_r << BITS_PER_BEAT_SINGLE) | DATA_W'(io_in[1]);
      tx_next_s = tx_sh_r << BITS_PER_BEAT_SINGLE;
    end
  end

  // Pad data comes straight from the transmit register MSBs while a word is on the wire.
  always_comb begin
    io_out_s = 4'b0000;
    if ((state_r == ST_SHIFT) || (state_r == ST_TAIL)) begin
      if (quad_r) begin
        io_out_s = tx_sh_r[DATA_W-1 -: 4];
      end else begin
        io_out_s = {3'b000, tx_sh_r[DATA_W-1]};
      end
    end else begin
      io_out_s = 4'b0000;
    end
  end

  // Main FSM and datapath; a rise tick always takes priority over a simultaneous fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tx_sh_r    <= {DATA_W{1'b0}};
      rx_sh_r    <= {DATA_W{1'b0}};
      quad_r     <= 1'b0;
      beat_cnt_r <= {CNT_W{1'b0}};
      sclk_r     <= 1'b0;
      sclk_ena_r <= 1'b0;
      io_oe_r    <= 4'b0000;
      ready_r    <= 1'b1;
      rx_data_r  <= {DATA_W{1'b0}};
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd.start && ready_r) begin
            tx_sh_r    <= cmd.tx_data;
            rx_sh_r    <= {DATA_W{1'b0}};
            quad_r     <= cmd.quad;
            beat_cnt_r <= {CNT_W{1'b0}};
            io_oe_r    <= oe_for_mode(cmd.quad, cmd.dir_rx);
            sclk_ena_r <= 1'b1;
            ready_r    <= 1'b0;
            state_r    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            sclk_r     <= 1'b1;
            rx_sh_r    <= rx_next_s;
            beat_cnt_r <= cnt_inc_s;
            if (cnt_inc_s == beats_s) begin
              state_r <= ST_TAIL;
            end
          end else if (sclk_fall && sclk_r) begin
            // A stray fall before the first rise must not consume the first beat.
            sclk_r  <= 1'b0;
            tx_sh_r <= tx_next_s;
          end
        end
        ST_TAIL: begin
          if (sclk_fall) begin
            sclk_r     <= 1'b0;
            sclk_ena_r <= 1'b0;
            io_oe_r    <= 4'b0000;
            rx_data_r  <= rx_sh_r;
            rx_valid_r <= 1'b1;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          sclk_r     <= 1'b0;
          sclk_ena_r <= 1'b0;
          io_oe_r    <= 4'b0000;
          ready_r    <= 1'b1;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign sclk         = sclk_r;
  assign sclk_ena     = sclk_ena_r;
  assign io_out       = io_out_s;
  assign io_oe        = io_oe_r;
  assign cmd.ready    = ready_r;
  assign cmd.rx_data  = rx_data_r;
  assign cmd.rx_valid = rx_valid_r;

endmodule

// File: tb/tb_qspi_shift_engine.sv
// Directed bench for qspi_shift_engine: a table of single/quad words plus
// hand-written reset-abort and tick-collision sequences.
module tb_qspi_shift_engine;

  logic       clk;
  logic       rst;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       sclk_ena;
  logic       sclk;
  logic [3:0] io_out;
  logic [3:0] io_oe;
  logic [3:0] io_in;

  qspi_shift_engine_if #(.DATA_W(8)) cmd_if ();

  qspi_shift_engine #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .sclk_ena  (sclk_ena),
    .sclk      (sclk),
    .io_out    (io_out),
    .io_oe     (io_oe),
    .io_in     (io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int valid_cnt = 0;

  always @(negedge clk) begin
    if (cmd_if.rx_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  typedef struct {
    bit         quad;
    bit         dir_rx;
    bit         loop;
    logic [7:0] tx;
    logic [7:0] rxw;
    logic [7:0] exp_rx;
    logic [3:0] exp_oe;
    bit         chk_io;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit r, input bit f);
    sclk_rise = r;
    sclk_fall = f;
    @(posedge clk);
    #1;
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
  endtask

  task automatic run_word(input vec_t v, input int glitch_beat, input bit mid_start, input string tag);
    int         nbeats;
    int         vc0;
    logic [7:0] col;
    nbeats = v.quad ? 2 : 8;
    col    = 8'h00;
    vc0    = valid_cnt;
    check({tag, "_ready_before"}, {31'd0, cmd_if.ready}, 32'd1);
    cmd_if.start   = 1'b1;
    cmd_if.quad    = v.quad;
    cmd_if.dir_rx  = v.dir_rx;
    cmd_if.tx_data = v.tx;
    idle(1);
    cmd_if.start   = 1'b0;
    cmd_if.tx_data = ~v.tx;
    check({tag, "_oe_accept"}, {28'd0, io_oe}, {28'd0, v.exp_oe});
    check({tag, "_ena_accept"}, {31'd0, sclk_ena}, 32'd1);
    check({tag, "_busy"}, {31'd0, cmd_if.ready}, 32'd0);
    for (int b = 0; b < nbeats; b++) begin
      if (v.quad) begin
        io_in = v.rxw[7-4*b -: 4];
        col   = {col[3:0], io_out};
      end else begin
        io_in = {2'b00, (v.loop ? io_out[0] : v.rxw[7-b]), 1'b0};
        col   = {col[6:0], io_out[0]};
      end
      if (mid_start && b == 3) cmd_if.start = 1'b1;
      if (b == glitch_beat) begin
        tick(1'b1, 1'b1);
        check({tag, "_glitch_sclk_high"}, {31'd0, sclk}, 32'd1);
      end else begin
        tick(1'b1, 1'b0);
      end
      cmd_if.start = 1'b0;
      if (b == 0) check({tag, "_oe_rise1"}, {28'd0, io_oe}, {28'd0, v.exp_oe});
      idle(1);
      tick(1'b0, 1'b1);
      if (b < nbeats - 1) idle(1);
    end
    if (v.chk_io) check({tag, "_io_seq"}, {24'd0, col}, {24'd0, v.tx});
    check({tag, "_rx_valid"}, {31'd0, cmd_if.rx_valid}, 32'd1);
    check({tag, "_rx_data"}, {24'd0, cmd_if.rx_data}, {24'd0, v.exp_rx});
    check({tag, "_sclk_low"}, {31'd0, sclk}, 32'd0);
    check({tag, "_oe_off"}, {28'd0, io_oe}, 32'd0);
    check({tag, "_ena_off"}, {31'd0, sclk_ena}, 32'd0);
    idle(1);
    check({tag, "_ready_after"}, {31'd0, cmd_if.ready}, 32'd1);
    check({tag, "_valid_pulse"}, valid_cnt - vc0, 32'd1);
  endtask

  initial begin
    vec_t hv;
    rst            = 1'b1;
    sclk_rise      = 1'b0;
    sclk_fall      = 1'b0;
    io_in          = 4'h0;
    cmd_if.start   = 1'b0;
    cmd_if.quad    = 1'b0;
    cmd_if.dir_rx  = 1'b0;
    cmd_if.tx_data = 8'h00;

    vecs[0] = '{quad:1'b0, dir_rx:1'b0, loop:1'b0, tx:8'hA5, rxw:8'hC3, exp_rx:8'hC3, exp_oe:4'b0001, chk_io:1'b1};
    vecs[1] = '{quad:1'b1, dir_rx:1'b0, loop:1'b0, tx:8'h3C, rxw:8'h7E, exp_rx:8'h7E, exp_oe:4'b1111, chk_io:1'b1};
    vecs[2] = '{quad:1'b1, dir_rx:1'b1, loop:1'b0, tx:8'h00, rxw:8'h96, exp_rx:8'h96, exp_oe:4'b0000, chk_io:1'b0};
    vecs[3] = '{quad:1'b0, dir_rx:1'b0, loop:1'b1, tx:8'h5A, rxw:8'h00, exp_rx:8'h5A, exp_oe:4'b0001, chk_io:1'b1};
    vecs[4] = '{quad:1'b0, dir_rx:1'b1, loop:1'b0, tx:8'hFF, rxw:8'h00, exp_rx:8'h00, exp_oe:4'b0001, chk_io:1'b1};

    idle(2);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_ena", {31'd0, sclk_ena}, 32'd0);
    check("rst_io_out", {28'd0, io_out}, 32'd0);
    check("rst_io_oe", {28'd0, io_oe}, 32'd0);
    check("rst_ready", {31'd0, cmd_if.ready}, 32'd1);
    check("rst_rx_data", {24'd0, cmd_if.rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, cmd_if.rx_valid}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Ticks while idle must not start anything.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    check("idle_ticks_sclk", {31'd0, sclk}, 32'd0);
    check("idle_ticks_ready", {31'd0, cmd_if.ready}, 32'd1);

    // Reset in the middle of a single-mode word.
    cmd_if.start   = 1'b1;
    cmd_if.quad    = 1'b0;
    cmd_if.tx_data = 8'h81;
    idle(1);
    cmd_if.start = 1'b0;
    io_in        = 4'b0010;
    for (int b = 0; b < 3; b++) begin
      tick(1'b1, 1'b0);
      if (b < 2) begin
        idle(1);
        tick(1'b0, 1'b1);
        idle(1);
      end
    end
    check("abort_sclk_before", {31'd0, sclk}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_sclk", {31'd0, sclk}, 32'd0);
    check("abort_oe", {28'd0, io_oe}, 32'd0);
    check("abort_io_out", {28'd0, io_out}, 32'd0);
    check("abort_ready", {31'd0, cmd_if.ready}, 32'd1);
    check("abort_ena", {31'd0, sclk_ena}, 32'd0);
    check("abort_rx_data", {24'd0, cmd_if.rx_data}, 32'd0);
    idle(1);
    rst = 1'b0;
    io_in = 4'h0;
    idle(3);
    check("abort_no_valid", valid_cnt, 32'd0);

    // Table vectors, each started on the first ready cycle after the previous word.
    for (int i = 0; i < 5; i++) begin
      run_word(vecs[i], -1, 1'b0, $sformatf("vec%0d", i));
    end

    // Mid-word start is ignored and a rise+fall collision drops the fall.
    hv = '{quad:1'b0, dir_rx:1'b0, loop:1'b1, tx:8'h3C, rxw:8'h00, exp_rx:8'h3C, exp_oe:4'b0001, chk_io:1'b1};
    run_word(hv, 4, 1'b1, "collide");
    idle(2);
    check("collide_not_queued_ready", {31'd0, cmd_if.ready}, 32'd1);
    check("collide_not_queued_ena", {31'd0, sclk_ena}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
